mrelbp_frame_ctrl: RTL and testbench

Frame-level sequencer for the MRELBP core. It launches a frame on a start request and latches the core configuration. It admits exactly IMG_W*IMG_H pixels from the input AXI-Stream into the core, then counts HIST_LEN histogram words leaving on the output stream. At frame end it raises a level interrupt and status; a watchdog flags a stalled frame.
Sits between the AXI-Lite register block (start/cfg/irq_clr/abort) and the mrelbp datapath plus its stream ports.

---
 rtl/mrelbp_frame_ctrl_if.sv | 24 ++
 rtl/mrelbp_frame_ctrl.sv | 138 +++++++++++++
 tb/tb_mrelbp_frame_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mrelbp_frame_ctrl_if.sv
// Stream handshake bundle between the frame controller, the upstream
// pixel source, the MRELBP core and the downstream histogram sink.
interface mrelbp_frame_ctrl_if;
  logic s_axis_tvalid;
  logic s_axis_tready;
  logic core_in_ready;
  logic core_in_valid;
  logic core_out_valid;
  logic m_axis_tready;
  logic core_out_ready;
  logic m_axis_tvalid;

  // Controller side: gates the handshakes in both directions.
  modport slave (
    input  s_axis_tvalid, core_in_ready, core_out_valid, m_axis_tready,
    output s_axis_tready, core_in_valid, core_out_ready, m_axis_tvalid
  );

  // Environment side: source, core and sink.
  modport master (
    output s_axis_tvalid, core_in_ready, core_out_valid, m_axis_tready,
    input  s_axis_tready, core_in_valid, core_out_ready, m_axis_tvalid
  );
endinterface

// File: rtl/mrelbp_frame_ctrl.sv
// Frame sequencer for the MRELBP core: latches configuration on start,
// clears the core, admits exactly IMG_W*IMG_H pixels, counts HIST_LEN
// histogram words out, and reports completion, abort or watchdog stall.
module mrelbp_frame_ctrl #(
  parameter int unsigned IMG_W    = 128,
  parameter int unsigned IMG_H    = 128,
  parameter int unsigned HIST_LEN = 200,
  parameter int unsigned CFG_W    = 3,
  parameter int unsigned WDOG_CYC = 65536,
  localparam int unsigned PIX_W   = $clog2(IMG_W*IMG_H+1),
  localparam int unsigned OUT_W   = $clog2(HIST_LEN+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CFG_W-1:0] cfg,
  input  logic             irq_clr,
  input  logic             abort,
  mrelbp_frame_ctrl_if.slave bus,
  output logic             core_clear,
  output logic [CFG_W-1:0] cfg_q,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             irq,
  output logic [PIX_W-1:0] pix_cnt,
  output logic [OUT_W-1:0] out_cnt
);

  localparam int unsigned WD_W = $clog2(WDOG_CYC+1);
  localparam logic [PIX_W-1:0] PIX_LIM  = PIX_W'(IMG_W*IMG_H);
  localparam logic [OUT_W-1:0] HIST_LIM = OUT_W'(HIST_LEN);
  localparam logic [WD_W-1:0]  WD_LIM   = WD_W'(WDOG_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE
  } state_t;

  state_t           state_q;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             clear_q, busy_q, done_q, tmo_q;
  logic             in_open, out_open, in_beat, out_beat;

  // Handshake gating and next values of the frame counters / watchdog.
  always_comb begin
    in_open  = (state_q == S_FEED);
    out_open = (state_q == S_FEED) || (state_q == S_DRAIN);
    in_beat  = in_open  & bus.s_axis_tvalid  & bus.core_in_ready;
    out_beat = out_open & bus.core_out_valid & bus.m_axis_tready;
    pix_d    = pix_q + PIX_W'(in_beat);
    out_d    = out_q + OUT_W'(out_beat);
    wdog_d   = (in_beat | out_beat) ? '0 : wdog_q + WD_W'(1);
  end

  assign bus.s_axis_tready  = in_open  & bus.core_in_ready;
  assign bus.core_in_valid  = in_open  & bus.s_axis_tvalid;
  assign bus.core_out_ready = out_open & bus.m_axis_tready;
  assign bus.m_axis_tvalid  = out_open & bus.core_out_valid;

  // Frame state machine with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      pix_q   <= '0;
      out_q   <= '0;
      wdog_q  <= '0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cfg_q   <= cfg;
            pix_q   <= '0;
            out_q   <= '0;
            wdog_q  <= '0;
            tmo_q   <= 1'b0;
            clear_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_CLEAR;
          end else if (irq_clr) begin
            tmo_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_FEED;
          end
        end
        S_FEED, S_DRAIN: begin
          // Beats in the exit cycle are still counted: they did handshake.
          pix_q  <= pix_d;
          out_q  <= out_d;
          wdog_q <= wdog_d;
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (wdog_d == WD_LIM) begin
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (out_d == HIST_LIM) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else if (in_open && pix_d == PIX_LIM) begin
            state_q <= S_DRAIN;
          end
        end
        S_DONE: begin
          if (irq_clr) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_clear = clear_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = tmo_q;
  assign irq        = done_q | tmo_q;
  assign pix_cnt    = pix_q;
  assign out_cnt    = out_q;

endmodule

// File: tb/tb_mrelbp_frame_ctrl.sv
// Bench for the MRELBP frame sequencer: a short directed vector table,
// hand sequences for the multi-cycle corners, then random traffic, all
// compared cycle by cycle against a flag-based behavioural model.
module tb_mrelbp_frame_ctrl;
  localparam int W = 4, H = 4, HL = 3, CW = 3, WD = 10;
  localparam int TOT = W * H;
  localparam int PW = $clog2(TOT + 1);
  localparam int OW = $clog2(HL + 1);

  logic          clk = 1'b0;
  logic          rst, start, irq_clr, abort;
  logic [CW-1:0] cfg;
  logic          core_clear, busy, done, timeout, irq;
  logic [CW-1:0] cfg_q;
  logic [PW-1:0] pix_cnt;
  logic [OW-1:0] out_cnt;

  mrelbp_frame_ctrl_if bus();

  mrelbp_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .HIST_LEN(HL), .CFG_W(CW), .WDOG_CYC(WD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg(cfg), .irq_clr(irq_clr),
    .abort(abort), .bus(bus), .core_clear(core_clear), .cfg_q(cfg_q),
    .busy(busy), .done(done), .timeout(timeout), .irq(irq),
    .pix_cnt(pix_cnt), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_active, m_clr, m_done, m_tmo;
  int m_pix, m_wrd, m_idle, m_cfg;

  task automatic model_reset();
    m_active = 0; m_clr = 0; m_done = 0; m_tmo = 0;
    m_pix = 0; m_wrd = 0; m_idle = 0; m_cfg = 0;
  endtask

  function automatic bit m_in_open();
    return m_active && !m_clr && (m_pix < TOT);
  endfunction

  function automatic bit m_out_open();
    return m_active && !m_clr;
  endfunction

  task automatic model_edge();
    bit inb, outb;
    if (m_done) begin
      if (irq_clr) m_done = 0;
    end else if (!m_active) begin
      if (start) begin
        m_cfg = int'(cfg); m_pix = 0; m_wrd = 0; m_idle = 0;
        m_tmo = 0; m_active = 1; m_clr = 1;
      end else if (irq_clr) m_tmo = 0;
    end else if (m_clr) begin
      m_clr = 0;
      if (abort) m_active = 0;
    end else begin
      inb  = m_in_open()  && bus.s_axis_tvalid  && bus.core_in_ready;
      outb = m_out_open() && bus.core_out_valid && bus.m_axis_tready;
      m_pix += int'(inb);
      m_wrd += int'(outb);
      m_idle = (inb || outb) ? 0 : m_idle + 1;
      if (abort) m_active = 0;
      else if (m_idle == WD) begin m_tmo = 1; m_active = 0; end
      else if (m_wrd == HL) begin m_done = 1; m_active = 0; end
    end
  endtask

  task automatic check_all();
    chk("s_axis_tready",  int'(bus.s_axis_tready),  int'(m_in_open()  && bus.core_in_ready));
    chk("core_in_valid",  int'(bus.core_in_valid),  int'(m_in_open()  && bus.s_axis_tvalid));
    chk("core_out_ready", int'(bus.core_out_ready), int'(m_out_open() && bus.m_axis_tready));
    chk("m_axis_tvalid",  int'(bus.m_axis_tvalid),  int'(m_out_open() && bus.core_out_valid));
    chk("core_clear", int'(core_clear), int'(m_clr));
    chk("busy",       int'(busy),       int'(m_active));
    chk("done",       int'(done),       int'(m_done));
    chk("timeout",    int'(timeout),    int'(m_tmo));
    chk("irq",        int'(irq),        int'(m_done || m_tmo));
    chk("cfg_q",      int'(cfg_q),      m_cfg);
    chk("pix_cnt",    int'(pix_cnt),    m_pix);
    chk("out_cnt",    int'(out_cnt),    m_wrd);
  endtask

  // Inputs are driven just after a falling edge; sample #1 later.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input bit st, input int c, input bit ab, input bit ic,
                       input bit tv, input bit cir, input bit cov, input bit mtr);
    start = st; cfg = CW'(c); abort = ab; irq_clr = ic;
    bus.s_axis_tvalid = tv; bus.core_in_ready = cir;
    bus.core_out_valid = cov; bus.m_axis_tready = mtr;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Feeds pixels with all-ready handshakes and emits words once draining.
  task automatic run_to_done(input string nm);
    int n;
    for (n = 0; n < 200 && !m_done; n++) begin
      drive(0, 0, 0, 0, 1, 1, m_active && !m_clr && m_pix == TOT, 1);
      step();
    end
    chk({nm, "_done"}, int'(done), 1);
  endtask

  task automatic ack_irq();
    idle_in(); irq_clr = 1; step(); irq_clr = 0; step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit st; int c; bit ab; bit tv; bit cir;
    bit e_clr; bit e_busy; bit e_trdy; int e_pix; int e_cfg; bit e_irq;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int lowcnt, n;
    tbl[0] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 2, 0, 1, 1,  0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 1, 1,  1, 1, 0, 0, 2, 0};
    tbl[3] = '{0, 0, 0, 1, 1,  0, 1, 1, 0, 2, 0};
    tbl[4] = '{0, 0, 0, 1, 0,  0, 1, 0, 1, 2, 0};
    tbl[5] = '{0, 0, 0, 0, 1,  0, 1, 1, 1, 2, 0};
    tbl[6] = '{1, 5, 0, 1, 1,  0, 1, 1, 1, 2, 0};
    tbl[7] = '{0, 0, 1, 0, 1,  0, 1, 1, 2, 2, 0};
    tbl[8] = '{0, 0, 0, 0, 0,  0, 0, 0, 2, 2, 0};

    idle_in(); rst = 1; model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 0;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].st, tbl[i].c, tbl[i].ab, 0, tbl[i].tv, tbl[i].cir, 0, 0);
      #1;
      chk($sformatf("tbl%0d_core_clear", i), int'(core_clear), int'(tbl[i].e_clr));
      chk($sformatf("tbl%0d_busy", i),       int'(busy),       int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_tready", i),     int'(bus.s_axis_tready), int'(tbl[i].e_trdy));
      chk($sformatf("tbl%0d_pix_cnt", i),    int'(pix_cnt),    tbl[i].e_pix);
      chk($sformatf("tbl%0d_cfg_q", i),      int'(cfg_q),      tbl[i].e_cfg);
      chk($sformatf("tbl%0d_irq", i),        int'(irq),        int'(tbl[i].e_irq));
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    // Nominal frame.
    drive(1, 2, 0, 0, 0, 0, 0, 0); step();
    run_to_done("nominal");
    chk("nominal_pix", int'(pix_cnt), TOT);
    chk("nominal_out", int'(out_cnt), HL);
    chk("nominal_cfg", int'(cfg_q), 2);
    ack_irq();
    chk("nominal_irq_cleared", int'(irq), 0);

    // Backpressure: input ready toggles, output stalls 5 cycles after word 1.
    drive(1, 3, 0, 0, 0, 0, 0, 0); step();
    lowcnt = 0;
    for (n = 0; n < 300 && !m_done; n++) begin
      bit mtr;
      mtr = !(m_wrd >= 1 && lowcnt < 5);
      if (!mtr) lowcnt++;
      drive(0, 0, 0, 0, 1, n % 2 == 0, m_active && !m_clr && m_pix == TOT, mtr);
      step();
    end
    chk("bp_done", int'(done), 1);
    chk("bp_pix", int'(pix_cnt), TOT);
    chk("bp_out", int'(out_cnt), HL);
    ack_irq();

    // Overrun: tvalid held for 20 beats, only TOT admitted.
    drive(1, 1, 0, 0, 0, 0, 0, 0); step();
    for (n = 0; n < 20; n++) begin drive(0, 0, 0, 0, 1, 1, 0, 1); step(); end
    chk("ovr_pix", int'(pix_cnt), TOT);
    drive(0, 0, 0, 0, 1, 1, 0, 1); #1;
    chk("ovr_tready_drain", int'(bus.s_axis_tready), 0);
    for (n = 0; n < 50 && !m_done; n++) begin drive(0, 0, 0, 0, 1, 1, 1, 1); step(); end
    drive(0, 0, 0, 0, 0, 0, 1, 1); #1;
    chk("ovr_done_out_ready", int'(bus.core_out_ready), 0);
    chk("ovr_done_tvalid", int'(bus.m_axis_tvalid), 0);
    step();
    chk("ovr_out", int'(out_cnt), HL);
    ack_irq();

    // Watchdog: 5 pixels then silence.
    drive(1, 4, 0, 0, 0, 0, 0, 0); step();
    for (n = 0; n < 50 && m_pix < 5; n++) begin drive(0, 0, 0, 0, 1, 1, 0, 0); step(); end
    for (n = 0; n < 30 && !m_tmo; n++) begin drive(0, 0, 0, 0, 0, 1, 0, 1); step(); end
    chk("wd_timeout", int'(timeout), 1);
    chk("wd_irq", int'(irq), 1);
    chk("wd_done", int'(done), 0);
    chk("wd_busy", int'(busy), 0);
    chk("wd_pix", int'(pix_cnt), 5);
    drive(1, 5, 0, 0, 0, 0, 0, 0); step();
    idle_in(); step();
    chk("wd_cleared_by_start", int'(timeout), 0);

    // Abort after 7 pixels of the frame just started; mid-frame start ignored.
    for (n = 0; n < 50 && m_pix < 7; n++) begin
      drive(n == 3, 6, 0, 0, 1, 1, 0, 0); step();
    end
    chk("abort_cfg_kept", int'(cfg_q), 5);
    drive(0, 0, 1, 0, 0, 1, 0, 0); step();
    idle_in(); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_irq", int'(irq), 0);
    chk("abort_pix", int'(pix_cnt), 7);
    step();

    // Asynchronous reset while draining.
    drive(1, 7, 0, 0, 0, 0, 0, 0); step();
    for (n = 0; n < 40 && m_pix < TOT; n++) begin drive(0, 0, 0, 0, 1, 1, 0, 1); step(); end
    chk("rst_in_drain_busy", int'(busy), 1);
    drive(0, 0, 0, 0, 1, 1, 1, 1);
    #2 rst = 1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_cfg_q", int'(cfg_q), 0);
    chk("rst_pix", int'(pix_cnt), 0);
    chk("rst_tvalid", int'(bus.m_axis_tvalid), 0);
    chk("rst_out_ready", int'(bus.core_out_ready), 0);
    model_reset();
    @(negedge clk); rst = 0;
    drive(1, 2, 0, 0, 0, 0, 0, 0); step();
    run_to_done("post_rst");
    chk("post_rst_pix", int'(pix_cnt), TOT);
    ack_irq();

    // Random traffic against the model.
    for (n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) < 10, $urandom_range(0, 7),
            $urandom_range(0, 199) < 1, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < (m_pix == TOT ? 60 : 5),
            $urandom_range(0, 99) < 70);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
